// File: rtl/fft_radix2_stream.sv
// fft_radix2_stream: streaming in-place radix-2 DIT FFT/IFFT, one butterfly per cycle, 1/N scaling.
// Frames load in bit-reversed order, compute stage by stage, then unload bins in natural order.
module fft_radix2_stream #(
    parameter int N      = 8,
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              inverse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);
    localparam int SW  = $clog2(LOG2N) + 1;
    localparam int KW  = LOG2N - 1;
    localparam int PW  = DATA_W + TW_W + 1;
    localparam int DW1 = DATA_W + 1;
    localparam logic [LOG2N-1:0] HALF     = LOG2N'(N / 2);
    localparam logic [LOG2N-1:0] LAST_CC  = LOG2N'(N / 2 + 1);
    localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);
    localparam logic [SW-1:0]    LAST_STG = SW'(LOG2N - 1);

    if ((1 << LOG2N) != N || LOG2N < 2 || LOG2N > 10) begin : g_bad_params
        $error("fft_radix2_stream: LOG2N must equal log2(N) with N in 4..1024");
    end

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t state, state_nx;
    logic [LOG2N-1:0] cnt, cc, ai, bi, half, pos, p_ai, p_bi;
    logic [SW-1:0] stg;
    logic [KW-1:0] tk;
    logic inv, accept, xfer, issue, stage_end, p_v;
    logic signed [DATA_W-1:0] mem_re [N];
    logic signed [DATA_W-1:0] mem_im [N];
    logic signed [TW_W-1:0] tw_cos [N/2];
    logic signed [TW_W-1:0] tw_sin [N/2];
    logic signed [TW_W-1:0] w_re, w_im;
    logic signed [DATA_W-1:0] t_re, t_im, p_are, p_aim, p_tre, p_tim;

    // Twiddle ROM, rounded to nearest; W^0 saturates at 2^(TW_W-1)-1
    for (genvar k = 0; k < N / 2; k++) begin : g_tw
        localparam real ANG = 6.283185307179586 * k / N;
        localparam real SC  = real'((1 << (TW_W - 1)) - 1);
        assign tw_cos[k] = TW_W'($rtoi(SC * $cos(ANG) + ($cos(ANG) < 0.0 ? -0.5 : 0.5)));
        assign tw_sin[k] = TW_W'($rtoi(SC * $sin(ANG) + ($sin(ANG) < 0.0 ? -0.5 : 0.5)));
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
    endfunction

    always_comb begin
        in_ready  = state == LOAD;
        busy      = state != LOAD;
        out_valid = state == UNLOAD;
        out_idx   = out_valid ? cnt : '0;
        out_last  = out_valid && cnt == LAST_CNT;
        out_re    = out_valid ? mem_re[cnt] : '0;
        out_im    = out_valid ? mem_im[cnt] : '0;
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        issue     = state == COMPUTE && cc < HALF;
        stage_end = state == COMPUTE && cc == LAST_CC;
        // Butterfly j of stage s pairs (group*2*half + pos) with its partner half away
        half = LOG2N'(1) << stg;
        pos  = cc & (half - LOG2N'(1));
        ai   = ((cc >> stg) << (stg + SW'(1))) | pos;
        bi   = ai | half;
        tk   = KW'(pos << (LAST_STG - stg));
        w_re = tw_cos[tk];
        w_im = inv ? tw_sin[tk] : -tw_sin[tk];
        t_re = DATA_W'((PW'(mem_re[bi]) * PW'(w_re) - PW'(mem_im[bi]) * PW'(w_im)) >>> (TW_W - 1));
        t_im = DATA_W'((PW'(mem_re[bi]) * PW'(w_im) + PW'(mem_im[bi]) * PW'(w_re)) >>> (TW_W - 1));
        state_nx = state;
        if (accept && cnt == LAST_CNT) state_nx = COMPUTE;
        if (stage_end && stg == LAST_STG) state_nx = UNLOAD;
        if (xfer && cnt == LAST_CNT) state_nx = LOAD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
            cc    <= '0;
            stg   <= '0;
            inv   <= 1'b0;
            p_v   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept || xfer) cnt <= cnt + LOG2N'(1);
            if (accept && cnt == '0) inv <= inverse;
            cc <= (state == COMPUTE && !stage_end) ? cc + LOG2N'(1) : '0;
            if (stage_end) stg <= (stg == LAST_STG) ? '0 : stg + SW'(1);
            p_v <= issue;
        end
    end

    // Two-stage butterfly: read/multiply registers a and t, then add/halve/write back
    always_ff @(posedge clk) begin
        p_ai  <= ai;
        p_bi  <= bi;
        p_are <= mem_re[ai];
        p_aim <= mem_im[ai];
        p_tre <= t_re;
        p_tim <= t_im;
        if (accept) begin
            mem_re[bitrev(cnt)] <= in_re;
            mem_im[bitrev(cnt)] <= in_im;
        end
        if (p_v) begin
            mem_re[p_ai] <= DATA_W'((DW1'(p_are) + DW1'(p_tre)) >>> 1);
            mem_im[p_ai] <= DATA_W'((DW1'(p_aim) + DW1'(p_tim)) >>> 1);
            mem_re[p_bi] <= DATA_W'((DW1'(p_are) - DW1'(p_tre)) >>> 1);
            mem_im[p_bi] <= DATA_W'((DW1'(p_aim) - DW1'(p_tim)) >>> 1);
        end
    end
endmodule

// File: tb/tb_fft_radix2_stream.sv
// tb_fft_radix2_stream: directed and randomized frames checked against a textbook integer DIT model.
module tb_fft_radix2_stream;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, inverse, out_valid, out_ready, out_last, busy;
    logic [15:0] in_re, in_im, out_re, out_im;
    logic [2:0] out_idx;
    int errors = 0;
    int checks = 0;
    int xr[8], xi[8], er[8], ei[8], gr[8], gi[8], orig[8];
    int wc[4] = '{32767, 23170, 0, -23170};
    int ws[4] = '{0, 23170, 32767, 23170};

    always #5 clk = ~clk;

    fft_radix2_stream #(.N(8), .LOG2N(3), .DATA_W(16), .TW_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inverse(inverse), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int got, input int exp, input int tol);
        checks++;
        assert ((got - exp <= tol && exp - got <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d +-%0d", tag, got, exp, tol);
        end
    endtask

    // Reference: bit-reverse the frame, then log2(8) passes of halving butterflies
    task automatic model(input bit inv);
        int ar[8], aim[8];
        logic [2:0] n3;
        for (int n = 0; n < 8; n++) begin
            n3 = 3'(n);
            ar[{n3[0], n3[1], n3[2]}] = xr[n];
            aim[{n3[0], n3[1], n3[2]}] = xi[n];
        end
        for (int h = 1; h < 8; h *= 2)
            for (int g = 0; g < 8; g += 2 * h)
                for (int p = 0; p < h; p++) begin
                    int k, a0, a1;
                    longint wr, wi, tr, ti;
                    k  = p * (8 / (2 * h));
                    wr = wc[k];
                    wi = inv ? ws[k] : -ws[k];
                    tr = (longint'(ar[g+p+h]) * wr - longint'(aim[g+p+h]) * wi) >>> 15;
                    ti = (longint'(ar[g+p+h]) * wi + longint'(aim[g+p+h]) * wr) >>> 15;
                    a0 = ar[g+p];
                    a1 = aim[g+p];
                    ar[g+p]    = (a0 + int'(tr)) >>> 1;
                    aim[g+p]   = (a1 + int'(ti)) >>> 1;
                    ar[g+p+h]  = (a0 - int'(tr)) >>> 1;
                    aim[g+p+h] = (a1 - int'(ti)) >>> 1;
                end
        er = ar;
        ei = aim;
    endtask

    // Leaves in_valid high with junk so the engine must ignore it while not ready
    task automatic send(input bit inv);
        int guard = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            inverse = (i == 0) ? inv : !inv;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            @(negedge clk);
        end
        in_re = 16'h5a5a;
        in_im = 16'ha5a5;
        chk("load_wait_bound", int'(guard < 100), 1);
        chk("in_ready_drop", int'(in_ready), 0);
        chk("busy_compute", int'(busy), 1);
    endtask

    task automatic recv(input int mode);
        int lat = 0, n = 0, cyc = 0, hr = 0, hi = 0, hx = 0;
        bit rdy, held = 1'b0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("compute_latency", lat, 18);
        while (n < 8 && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(1));
            out_ready = rdy;
            if (held) begin
                chk("stall_re", int'($signed(out_re)), hr);
                chk("stall_im", int'($signed(out_im)), hi);
                chk("stall_idx", int'(out_idx), hx);
            end
            chk("out_valid", int'(out_valid), 1);
            chk("out_idx", int'(out_idx), n);
            chk("out_last", int'(out_last), int'(n == 7));
            chk("in_ready_unload", int'(in_ready), 0);
            chk("busy_unload", int'(busy), 1);
            gr[n] = int'($signed(out_re));
            gi[n] = int'($signed(out_im));
            held = !rdy;
            hr = gr[n];
            hi = gi[n];
            hx = n;
            if (rdy) n++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("transfers", n, 8);
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
        chk("busy_drop", int'(busy), 0);
    endtask

    task automatic cmp_model(input string tag);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("%s_re[%0d]", tag, b), gr[b], er[b]);
            chk($sformatf("%s_im[%0d]", tag, b), gi[b], ei[b]);
        end
    endtask

    task automatic impulse_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            xr[i] = (i == 0) ? 16384 : 0;
            xi[i] = 0;
        end
        model(1'b0);
        send(1'b0);
        recv(0);
        cmp_model(tag);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("%s_spec_re[%0d]", tag, b), gr[b], 2048);
            chk($sformatf("%s_spec_im[%0d]", tag, b), gi[b], 0);
        end
    endtask

    initial begin
        int seen;
        int cosv[8] = '{8000, 5657, 0, -5657, -8000, -5657, 0, 5657};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_re = '0;
        in_im = '0;
        inverse = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_out_im", int'(out_im), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);

        impulse_frame("imp");

        for (int i = 0; i < 8; i++) begin
            xr[i] = 8192;
            xi[i] = 0;
        end
        model(1'b0);
        send(1'b0);
        recv(1);
        cmp_model("dc");
        chk_tol("dc_bin0_re", gr[0], 8192, 4);
        chk_tol("dc_bin0_im", gi[0], 0, 1);
        for (int b = 1; b < 8; b++) begin
            chk_tol($sformatf("dc_re[%0d]", b), gr[b], 0, 1);
            chk_tol($sformatf("dc_im[%0d]", b), gi[b], 0, 1);
        end

        xr = cosv;
        for (int i = 0; i < 8; i++) xi[i] = 0;
        model(1'b0);
        send(1'b0);
        recv(0);
        cmp_model("cos");
        for (int b = 0; b < 8; b++) begin
            chk_tol($sformatf("cos_re[%0d]", b), gr[b], (b == 1 || b == 7) ? 4000 : 0, 2);
            chk_tol($sformatf("cos_im[%0d]", b), gi[b], 0, 2);
        end

        for (int i = 0; i < 8; i++) begin
            xr[i] = int'($urandom_range(16382)) - 8191;
            xi[i] = int'($urandom_range(16382)) - 8191;
        end
        send(1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            seen |= int'(out_valid);
        end
        chk("midrst_no_bins", seen, 0);
        impulse_frame("imp_after_rst");

        for (int i = 0; i < 8; i++) begin
            xr[i] = 1000 * (i + 1);
            xi[i] = 0;
            orig[i] = xr[i];
        end
        model(1'b0);
        send(1'b0);
        recv(0);
        cmp_model("rt_fwd");
        xr = gr;
        xi = gi;
        model(1'b1);
        send(1'b1);
        recv(2);
        cmp_model("rt_inv");
        for (int i = 0; i < 8; i++) begin
            chk_tol($sformatf("rt_re[%0d]", i), gr[i], orig[i] / 8, 3);
            chk_tol($sformatf("rt_im[%0d]", i), gi[i], 0, 3);
        end

        for (int f = 0; f < 3; f++) begin
            bit inv;
            inv = 1'($urandom_range(1));
            for (int i = 0; i < 8; i++) begin
                xr[i] = int'($urandom_range(16382)) - 8191;
                xi[i] = int'($urandom_range(16382)) - 8191;
            end
            model(inv);
            send(inv);
            recv(2);
            cmp_model($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
